// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared fp32 constants, flag indices and converter FSM states
package fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_t;

  localparam logic [7:0]  FP32_BIAS     = 8'd127;
  localparam logic [7:0]  FP32_EXP_MAX  = 8'd255;
  localparam logic [7:0]  CONV_EXP_BASE = 8'd150;
  localparam logic [7:0]  CONV_EXP_OVF  = CONV_EXP_BASE + 8'd8;
  localparam logic [31:0] INT32_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN     = 32'h8000_0000;

  localparam int FLAG_INVALID = 1;
  localparam int FLAG_INEXACT = 0;

endpackage

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - fp32 field split and special-value classification
module fp32_classify
  import fp_pkg::*;
(
  input  logic [31:0] i_a,
  output logic        o_sign,
  output logic [7:0]  o_exp,
  output logic [22:0] o_frac,
  output logic        o_hidden,
  output logic [23:0] o_mant,
  output logic        o_is_nan,
  output logic        o_is_inf,
  output logic        o_is_zero_or_denorm
);

  assign o_sign              = i_a[31];
  assign o_exp               = i_a[30:23];
  assign o_frac              = i_a[22:0];
  assign o_hidden            = (o_exp != 8'd0);
  assign o_mant              = {o_hidden, o_frac};
  assign o_is_nan            = (o_exp == FP32_EXP_MAX) && (o_frac != 23'd0);
  assign o_is_inf            = (o_exp == FP32_EXP_MAX) && (o_frac == 23'd0);
  assign o_is_zero_or_denorm = (o_exp == 8'd0);

endmodule

// File: rtl/fp_to_int.sv
// rtl/fp_to_int.sv - multi-cycle fp32 to int32 converter, one shift bit per cycle
// FP_TO_INT_RNE_EN selects round-to-nearest-even; otherwise truncate toward zero.
module fp_to_int
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic [1:0]  out_flags
);

  logic        w_sign, w_hidden, w_is_nan, w_is_inf, w_is_zero;
  logic [7:0]  w_exp;
  logic [22:0] w_frac;
  logic [23:0] w_mant;

  fp32_classify u_classify (
    .i_a                 (in_a),
    .o_sign              (w_sign),
    .o_exp               (w_exp),
    .o_frac              (w_frac),
    .o_hidden            (w_hidden),
    .o_mant              (w_mant),
    .o_is_nan            (w_is_nan),
    .o_is_inf            (w_is_inf),
    .o_is_zero_or_denorm (w_is_zero)
  );

  conv_state_t r_state, w_next;
  logic [31:0] r_mag, r_spec_int;
  logic [7:0]  r_count;
  logic        r_sign, r_guard, r_sticky, r_left, r_special, r_spec_inv;

  logic w_sat, w_exact_min, w_tiny, w_left, w_to_shift;
  assign w_sat       = w_is_nan || w_is_inf || (w_exp >= CONV_EXP_OVF);
  assign w_exact_min = w_sign && (w_exp == CONV_EXP_OVF) && (w_frac == 23'd0);
  assign w_tiny      = !w_is_zero && (w_exp < (FP32_BIAS - 8'd1));
  assign w_left      = (w_exp >= CONV_EXP_BASE);
  assign w_to_shift  = !w_sat && !w_is_zero && !w_tiny && (w_exp != CONV_EXP_BASE);

  logic        w_inc, w_invalid, w_inexact;
  logic [31:0] w_rounded, w_result;
`ifdef FP_TO_INT_RNE_EN
  assign w_inc = r_guard && (r_sticky || r_mag[0]);
`else
  assign w_inc = 1'b0;
`endif
  assign w_rounded = r_mag + {31'd0, w_inc};

  // Specials carry a preloaded result; only a positive 2^31 can overflow after rounding.
  always_comb begin
    w_result  = r_spec_int;
    w_invalid = r_spec_inv;
    if (!r_special) begin
      if (w_rounded[31] && !r_sign) begin
        w_result  = INT32_MAX;
        w_invalid = 1'b1;
      end else begin
        w_result = r_sign ? (~w_rounded + 32'd1) : w_rounded;
      end
    end
  end
  assign w_inexact = (r_guard || r_sticky) && !w_invalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_to_shift ? ST_SHIFT : ST_ROUND;
      end
      ST_SHIFT: if (r_count == 8'd1) w_next = ST_ROUND;
      ST_ROUND: w_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag      <= 32'd0;
      r_spec_int <= 32'd0;
      r_count    <= 8'd0;
      r_sign     <= 1'b0;
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
      r_left     <= 1'b0;
      r_special  <= 1'b0;
      r_spec_inv <= 1'b0;
      out_int    <= 32'd0;
      out_flags  <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_sign     <= w_sign;
          r_mag      <= 32'd0;
          r_guard    <= 1'b0;
          r_sticky   <= 1'b0;
          r_left     <= 1'b0;
          r_count    <= 8'd0;
          r_special  <= 1'b0;
          r_spec_inv <= 1'b0;
          r_spec_int <= 32'd0;
          if (w_is_nan) begin
            r_special  <= 1'b1;
            r_spec_inv <= 1'b1;
            r_spec_int <= INT32_MAX;
          end else if (w_exact_min) begin
            r_special  <= 1'b1;
            r_spec_int <= INT32_MIN;
          end else if (w_sat) begin
            r_special  <= 1'b1;
            r_spec_inv <= 1'b1;
            r_spec_int <= w_sign ? INT32_MIN : INT32_MAX;
          end else if (w_is_zero) begin
            r_sticky <= |w_frac;
          end else if (w_tiny) begin
            r_sticky <= w_hidden;
          end else if (w_left) begin
            r_mag   <= {8'd0, w_mant};
            r_left  <= 1'b1;
            r_count <= w_exp - CONV_EXP_BASE;
          end else begin
            r_mag   <= {8'd0, w_mant};
            r_count <= CONV_EXP_BASE - w_exp;
          end
        end
        ST_SHIFT: begin
          r_count <= r_count - 8'd1;
          if (r_left) begin
            r_mag <= r_mag << 1;
          end else begin
            r_mag    <= r_mag >> 1;
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
          end
        end
        ST_ROUND: begin
          out_int                <= w_result;
          out_flags[FLAG_INVALID] <= w_invalid;
          out_flags[FLAG_INEXACT] <= w_inexact;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int.sv
// tb/tb_fp_to_int.sv - randomized self-checking bench for fp_to_int against a value-level model
module tb_fp_to_int;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, out_int;
  logic [1:0]  out_flags;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  bit seen  = 1'b0;

`ifdef FP_TO_INT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef struct {
    logic [31:0] iv;
    logic [1:0]  fl;
    int          lat;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_to_int dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .out_flags (out_flags)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_msg(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Value-level reference: real value M*2^(E-150), rounded, range-checked by magnitude.
  function automatic exp_t model(input logic [31:0] a);
    exp_t   r;
    bit     s;
    int     e, sh;
    longint m, ip, rem, half;
    s = a[31];
    e = int'(a[30:23]);
    m = longint'({(e != 0), a[22:0]});
    r.lat = (e == 255 || e >= 158 || e == 0 || e <= 125) ? 2 : ((e >= 150) ? e - 148 : 152 - e);
    if (e == 255 && a[22:0] != 23'd0) begin
      r.iv = 32'h7FFF_FFFF; r.fl = 2'b10; return r;
    end
    if (e == 255) begin
      r.iv = s ? 32'h8000_0000 : 32'h7FFF_FFFF; r.fl = 2'b10; return r;
    end
    rem  = 0;
    half = longint'(1) << 40;
    if (e >= 150) begin
      ip = (e - 150 > 32) ? (longint'(1) << 40) : (m << (e - 150));
    end else begin
      sh = 150 - e;
      if (sh > 40) begin
        ip = 0; rem = m;
      end else begin
        ip   = m >> sh;
        rem  = m - (ip << sh);
        half = longint'(1) << (sh - 1);
      end
    end
    if (RNE && (rem > half || (rem == half && ip[0]))) ip = ip + 1;
    if (!s && ip > 64'sd2147483647) begin
      r.iv = 32'h7FFF_FFFF; r.fl = 2'b10; return r;
    end
    if (s && ip > 64'sd2147483648) begin
      r.iv = 32'h8000_0000; r.fl = 2'b10; return r;
    end
    r.iv = s ? 32'(-ip) : 32'(ip);
    r.fl = {1'b0, (rem != 0)};
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      seen = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_int", 64'(out_int), 64'd0);
      chk("rst_out_flags", 64'(out_flags), 64'd0);
    end else begin
      chk("in_ready", 64'(in_ready), 64'(q.size() == 0));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("out_valid_unexpected", 64'(out_valid), 64'd0);
        end else begin
          if (!seen) begin
            chk($sformatf("latency[%0d]", q[0].lat), 64'(cyc - acc_cyc), 64'(q[0].lat));
            seen = 1'b1;
          end
          chk("out_int", 64'(out_int), 64'(q[0].iv));
          chk("out_flags", 64'(out_flags), 64'(q[0].fl));
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_a));
        acc_cyc = cyc;
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input int hold, input bit lit,
                       input logic [31:0] lit_int, input logic [1:0] lit_fl);
    int t;
    in_a     = a;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) fail_msg("accept_timeout");
    @(posedge clk); #1 in_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 60) begin @(negedge clk); t++; end
    if (!out_valid) begin
      fail_msg($sformatf("result_timeout[%h]", a));
      @(posedge clk); #1;
      return;
    end
    if (lit) begin
      chk($sformatf("lit_int[%h]", a), 64'(out_int), 64'(lit_int));
      chk($sformatf("lit_flags[%h]", a), 64'(out_flags), 64'(lit_fl));
    end
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    logic [31:0] a;
    int k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = 32'd0;

    m = model(32'h3FC0_0000);
    chk("model_lat_1p5", 64'(m.lat), 64'd25);
    chk("model_int_1p5", 64'(m.iv), RNE ? 64'd2 : 64'd1);
    m = model(32'h7FC0_0000);
    chk("model_lat_nan", 64'(m.lat), 64'd2);
    m = model(32'h4EFF_FFFF);
    chk("model_lat_big", 64'(m.lat), 64'd9);
    chk("model_int_big", 64'(m.iv), 64'h7FFF_FF80);
    m = model(32'hC060_0000);
    chk("model_int_m3p5", 64'(m.iv), RNE ? 64'hFFFF_FFFC : 64'hFFFF_FFFD);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_op(32'h3FC0_0000, 0, 1'b1, RNE ? 32'd2 : 32'd1, 2'b01);
    do_op(32'h4020_0000, 0, 1'b1, 32'd2, 2'b01);
    do_op(32'hC060_0000, 0, 1'b1, RNE ? 32'hFFFF_FFFC : 32'hFFFF_FFFD, 2'b01);
    do_op(32'h4EFF_FFFF, 0, 1'b1, 32'h7FFF_FF80, 2'b00);
    do_op(32'hCF00_0000, 0, 1'b1, 32'h8000_0000, 2'b00);
    do_op(32'h4F00_0000, 0, 1'b1, 32'h7FFF_FFFF, 2'b10);
    do_op(32'h7FC0_0000, 0, 1'b1, 32'h7FFF_FFFF, 2'b10);
    do_op(32'hFF80_0000, 0, 1'b1, 32'h8000_0000, 2'b10);
    do_op(32'h0000_0001, 0, 1'b1, 32'd0, 2'b01);
    do_op(32'h3F00_0000, 0, 1'b1, 32'd0, 2'b01);
    do_op(32'hBF80_0000, 5, 1'b1, 32'hFFFF_FFFF, 2'b00);
    do_op(32'h8000_0000, 0, 1'b1, 32'd0, 2'b00);

    @(posedge clk); #1;
    in_a = 32'h3FC0_0000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    do_op(32'h4120_0000, 0, 1'b1, 32'h0000_000A, 2'b00);

    for (int i = 0; i < 250; i++) begin
      a = $urandom;
      k = $urandom_range(0, 9);
      if (k < 6)       a[30:23] = 8'($urandom_range(120, 160));
      else if (k == 6) a[30:23] = 8'hFF;
      else if (k == 7) a[30:23] = 8'h00;
      else if (k == 8) a = {a[31], 8'd158, (a[0] ? 23'd0 : a[22:0])};
      do_op(a, $urandom_range(0, 3), 1'b0, 32'd0, 2'd0);
      k = $urandom_range(0, 2);
      repeat (k) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
